// File: rtl/mem_access_unit.sv
// Y86-64 SEQ data-memory stage: byte-serial, little-endian 64-bit access into an
// internal byte memory, with a start/busy/done handshake toward the sequencer.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] vala,
  input  logic [63:0] vale,
  input  logic [63:0] valp,
  output logic        busy,
  output logic        done,
  output logic [63:0] valm,
  output logic        dmem_error
);

  localparam int unsigned AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rd;
  logic        r_wr;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [2:0]  r_cnt;
  logic [55:0] r_shadow;
  logic [63:0] r_valm;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_mem [MEM_BYTES];

  logic        w_in_rd;
  logic        w_in_wr;
  logic [63:0] w_in_addr;
  logic [63:0] w_in_data;
  logic        w_fault;
  logic        w_xfer;
  logic [AW-1:0] w_idx;
  logic [7:0]  w_rbyte;

  // icode decode on the live inputs; only used at the capture edge
  always_comb begin
    w_in_rd   = 1'b0;
    w_in_wr   = 1'b0;
    w_in_addr = vale;
    w_in_data = vala;
    unique case (icode)
      4'h4, 4'hA: w_in_wr = 1'b1;
      4'h8: begin
        w_in_wr   = 1'b1;
        w_in_data = valp;
      end
      4'h5: w_in_rd = 1'b1;
      4'h9, 4'hB: begin
        w_in_rd   = 1'b1;
        w_in_addr = vala;
      end
      default: ;
    endcase
  end

  // Fault/no-op classification happens from the captured operands in the first ACCESS cycle
  assign w_fault = (r_rd | r_wr) && (r_addr > LAST_ADDR);
  assign w_xfer  = (r_state == S_ACCESS) && (r_rd | r_wr) && !w_fault;
  assign w_idx   = AW'(r_addr + 64'(r_cnt));
  assign w_rbyte = r_mem[w_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_ACCESS;
      S_ACCESS: if (!w_xfer || (r_cnt == 3'd7)) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_valm   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_ACCESS) && (w_next == S_DONE);
      if ((r_state == S_IDLE) && start) begin
        r_rd    <= w_in_rd;
        r_wr    <= w_in_wr;
        r_addr  <= w_in_addr;
        r_wdata <= w_in_data;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end
      if ((r_state == S_ACCESS) && !w_xfer) r_err <= w_fault;
      // Byte-serial transfer: write data shifts out LSB first, read bytes shift in from the top
      if (w_xfer) begin
        r_cnt   <= r_cnt + 3'd1;
        r_wdata <= {8'h00, r_wdata[63:8]};
        if (r_rd) begin
          r_shadow <= {w_rbyte, r_shadow[55:8]};
          if (r_cnt == 3'd7) r_valm <= {w_rbyte, r_shadow};
        end
      end
    end
  end

  // Memory array has no reset; contents survive rst
  always_ff @(posedge clk) begin
    if (w_xfer && r_wr) r_mem[w_idx] <= r_wdata[7:0];
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign valm       = r_valm;
  assign dmem_error = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-level reference memory predicts
// valm, dmem_error and latency for each accepted access.
module tb_mem_access_unit;

  localparam int unsigned MEM_BYTES = 1024;

  typedef struct {
    logic [3:0]  ic;
    logic [63:0] a;
    logic [63:0] e;
    logic [63:0] p;
  } op_t;

  typedef struct {
    logic [63:0] valm;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] vala, vale, valp;
  logic        busy, done, dmem_error;
  logic [63:0] valm;

  int          checks = 0;
  int          errors = 0;
  int          n_done = 0;
  exp_t        sb[$];
  logic [7:0]  mdl [logic [63:0]];
  logic [63:0] m_valm;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .vala(vala),
    .vale(vale), .valp(valp), .busy(busy), .done(done), .valm(valm),
    .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) n_done++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Reference behaviour: update the byte model and predict the DUT response
  function automatic exp_t model_op(input op_t o);
    exp_t x;
    logic rd, wr;
    logic [63:0] ad, d;
    rd = (o.ic == 4'h5) || (o.ic == 4'h9) || (o.ic == 4'hB);
    wr = (o.ic == 4'h4) || (o.ic == 4'h8) || (o.ic == 4'hA);
    ad = ((o.ic == 4'h9) || (o.ic == 4'hB)) ? o.a : o.e;
    d  = (o.ic == 4'h8) ? o.p : o.a;
    x.lat = 1;
    x.err = 1'b0;
    if (rd || wr) begin
      if (ad > 64'(MEM_BYTES - 8)) x.err = 1'b1;
      else begin
        x.lat = 8;
        for (int k = 0; k < 8; k++) begin
          if (wr) mdl[ad + 64'(k)] = d[k*8 +: 8];
          else    m_valm[k*8 +: 8] = mdl[ad + 64'(k)];
        end
      end
    end
    x.valm = m_valm;
    return x;
  endfunction

  // Drive one request, scramble inputs after capture, wait (bounded) for done
  task automatic issue(input op_t o, output int lat, output logic [63:0] vm,
                       output logic er, output logic bz, output bit to);
    start = 1'b1; icode = o.ic; vala = o.a; vale = o.e; valp = o.p;
    @(posedge clk); #1;
    start = 1'b0;
    icode = 4'($urandom);
    vala = {$urandom, $urandom}; vale = {$urandom, $urandom}; valp = {$urandom, $urandom};
    lat = 0; to = 1'b1; vm = '0; er = 1'b0; bz = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = c; vm = valm; er = dmem_error; to = 1'b0;
        break;
      end
    end
    if (!to) begin
      @(posedge clk); #1;
      bz = busy;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; icode = '0; vala = '0; vale = '0; valp = '0;
    m_valm = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, dmem_error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/err=%b want 000", {busy, done, dmem_error});
    end
    checks++;
    if (valm !== 64'h0) begin
      errors++;
      $display("FAIL reset_valm: got %h want 0", valm);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_write_read;
    op_t ops [3];
    exp_t x, got;
    int lat; logic [63:0] vm; logic er, bz; bit to;
    ops[0] = '{4'h4, 64'h0123456789ABCDEF, 64'h10, 64'h0};
    ops[1] = '{4'h5, 64'h0, 64'h10, 64'h0};
    ops[2] = '{4'hB, 64'h10, 64'h0, 64'h0};
    for (int i = 0; i < 3; i++) begin
      x = model_op(ops[i]);
      sb.push_back(x);
      issue(ops[i], lat, vm, er, bz, to);
      got = sb.pop_front();
      checks += 3;
      if (to || lat != got.lat) begin
        errors++;
        $display("FAIL wr_rd_latency op%0d: got %0d (timeout=%0b) want %0d", i, lat, to, got.lat);
      end
      if (vm !== got.valm) begin
        errors++;
        $display("FAIL wr_rd_valm op%0d: got %h want %h", i, vm, got.valm);
      end
      if ({er, bz} !== {got.err, 1'b0}) begin
        errors++;
        $display("FAIL wr_rd_err_busy op%0d: got %b want %b", i, {er, bz}, {got.err, 1'b0});
      end
    end
    checks++;
    if (dut.r_mem[16] !== 8'hEF) begin
      errors++;
      $display("FAIL byte_0x10: got %h want ef", dut.r_mem[16]);
    end
  endtask

  task automatic test_call_ret;
    op_t ops [2];
    exp_t x, got;
    int lat; logic [63:0] vm; logic er, bz; bit to;
    ops[0] = '{4'h8, 64'hDEAD, 64'h3F8, 64'h123};
    ops[1] = '{4'h9, 64'h3F8, 64'h0, 64'h0};
    for (int i = 0; i < 2; i++) begin
      x = model_op(ops[i]);
      sb.push_back(x);
      issue(ops[i], lat, vm, er, bz, to);
      got = sb.pop_front();
      checks += 3;
      if (to || lat != got.lat) begin
        errors++;
        $display("FAIL call_ret_latency op%0d: got %0d (timeout=%0b) want %0d", i, lat, to, got.lat);
      end
      if (vm !== got.valm) begin
        errors++;
        $display("FAIL call_ret_valm op%0d: got %h want %h", i, vm, got.valm);
      end
      if ({er, bz} !== {got.err, 1'b0}) begin
        errors++;
        $display("FAIL call_ret_err_busy op%0d: got %b want %b", i, {er, bz}, {got.err, 1'b0});
      end
    end
  endtask

  task automatic test_fault_boundary;
    op_t ops [6];
    exp_t x, got;
    int lat; logic [63:0] vm; logic er, bz; bit to;
    ops[0] = '{4'hA, 64'hCAFEF00DDEADBEEF, 64'(MEM_BYTES - 8), 64'h0};
    ops[1] = '{4'hA, 64'h1111111111111111, 64'(MEM_BYTES - 7), 64'h0};
    ops[2] = '{4'hA, 64'h2222222222222222, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0};
    ops[3] = '{4'h4, 64'h3333333333333333, 64'h1_0000_0010, 64'h0};
    ops[4] = '{4'h5, 64'h0, 64'(MEM_BYTES - 8), 64'h0};
    ops[5] = '{4'h9, 64'(MEM_BYTES - 7), 64'h0, 64'h0};
    for (int i = 0; i < 6; i++) begin
      x = model_op(ops[i]);
      sb.push_back(x);
      issue(ops[i], lat, vm, er, bz, to);
      got = sb.pop_front();
      checks += 3;
      if (to || lat != got.lat) begin
        errors++;
        $display("FAIL fault_latency op%0d: got %0d (timeout=%0b) want %0d", i, lat, to, got.lat);
      end
      if (vm !== got.valm) begin
        errors++;
        $display("FAIL fault_valm op%0d: got %h want %h", i, vm, got.valm);
      end
      if ({er, bz} !== {got.err, 1'b0}) begin
        errors++;
        $display("FAIL fault_err_busy op%0d: got %b want %b", i, {er, bz}, {got.err, 1'b0});
      end
      if (i == 1) begin
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dmem_error !== 1'b1) begin
          errors++;
          $display("FAIL fault_err_hold: got %b want 1", dmem_error);
        end
      end
    end
  endtask

  task automatic test_noop;
    op_t ops [3];
    exp_t x, got;
    int lat; logic [63:0] vm; logic er, bz; bit to;
    ops[0] = '{4'h6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    ops[1] = '{4'h0, 64'h10, 64'h10, 64'h10};
    ops[2] = '{4'h7, 64'h1234, 64'h3F8, 64'h55};
    for (int i = 0; i < 3; i++) begin
      x = model_op(ops[i]);
      sb.push_back(x);
      issue(ops[i], lat, vm, er, bz, to);
      got = sb.pop_front();
      checks += 3;
      if (to || lat != got.lat) begin
        errors++;
        $display("FAIL noop_latency op%0d: got %0d (timeout=%0b) want %0d", i, lat, to, got.lat);
      end
      if (vm !== got.valm) begin
        errors++;
        $display("FAIL noop_valm op%0d: got %h want %h", i, vm, got.valm);
      end
      if ({er, bz} !== {got.err, 1'b0}) begin
        errors++;
        $display("FAIL noop_err_busy op%0d: got %b want %b", i, {er, bz}, {got.err, 1'b0});
      end
    end
  endtask

  task automatic test_busy_ignore;
    op_t o;
    exp_t x, got;
    int lat, n0; logic [63:0] vm; logic er, bz; bit to;
    o = '{4'h4, 64'h5555AAAA5555AAAA, 64'h30, 64'h0};
    x = model_op(o);
    sb.push_back(x);
    n0 = n_done;
    fork
      issue(o, lat, vm, er, bz, to);
      begin
        repeat (3) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
      end
    join
    got = sb.pop_front();
    checks += 2;
    if (to || lat != got.lat) begin
      errors++;
      $display("FAIL busy_latency: got %0d (timeout=%0b) want %0d", lat, to, got.lat);
    end
    if ({er, bz} !== {got.err, 1'b0}) begin
      errors++;
      $display("FAIL busy_err_busy: got %b want %b", {er, bz}, {got.err, 1'b0});
    end
    repeat (12) @(posedge clk);
    #1;
    checks += 2;
    if (n_done - n0 != 1) begin
      errors++;
      $display("FAIL busy_done_count: got %0d want 1", n_done - n0);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_not_accepted: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_write;
    op_t ops [2];
    exp_t x, got;
    int lat, n0; logic [63:0] vm; logic er, bz; bit to;
    ops[0] = '{4'h4, 64'h0, 64'h20, 64'h0};
    ops[1] = '{4'h5, 64'h0, 64'h20, 64'h0};
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        start = 1'b1; icode = 4'h4; vale = 64'h20; vala = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) mdl[64'h20 + 64'(k)] = 8'hFF;
        m_valm = '0;
        n0 = n_done;
        #1;
        checks += 2;
        if ({busy, done} !== 2'b00) begin
          errors++;
          $display("FAIL rstmid_flags: got busy/done=%b want 00", {busy, done});
        end
        if (valm !== 64'h0) begin
          errors++;
          $display("FAIL rstmid_valm: got %h want 0", valm);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ((n_done != n0) || (busy !== 1'b0)) begin
          errors++;
          $display("FAIL rstmid_no_done: got dones=%0d busy=%b want 0 0", n_done - n0, busy);
        end
      end
      x = model_op(ops[i]);
      sb.push_back(x);
      issue(ops[i], lat, vm, er, bz, to);
      got = sb.pop_front();
      checks += 3;
      if (to || lat != got.lat) begin
        errors++;
        $display("FAIL rstmid_latency op%0d: got %0d (timeout=%0b) want %0d", i, lat, to, got.lat);
      end
      if (vm !== got.valm) begin
        errors++;
        $display("FAIL rstmid_valm op%0d: got %h want %h", i, vm, got.valm);
      end
      if ({er, bz} !== {got.err, 1'b0}) begin
        errors++;
        $display("FAIL rstmid_err_busy op%0d: got %b want %b", i, {er, bz}, {got.err, 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ics [8];
    op_t o;
    exp_t x, got;
    logic [63:0] ad, d;
    int lat; logic [63:0] vm; logic er, bz; bit to;
    ics = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'h3};
    for (int i = 0; i < 24; i++) begin
      d  = {$urandom, $urandom};
      ad = 64'h40 + 64'(8 * $urandom_range(0, 7));
      if (i < 8) begin
        o.ic = 4'h4;
        ad   = 64'h40 + 64'(8 * i);
      end else begin
        o.ic = ics[$urandom_range(0, 7)];
        if ($urandom_range(0, 7) == 0) ad = 64'(MEM_BYTES - 4);
      end
      o.p = {$urandom, $urandom};
      if ((o.ic == 4'h9) || (o.ic == 4'hB)) begin
        o.a = ad; o.e = {$urandom, $urandom};
      end else begin
        o.a = d; o.e = ad;
      end
      x = model_op(o);
      sb.push_back(x);
      issue(o, lat, vm, er, bz, to);
      got = sb.pop_front();
      checks += 3;
      if (to || lat != got.lat) begin
        errors++;
        $display("FAIL b2b_latency op%0d ic=%h: got %0d (timeout=%0b) want %0d", i, o.ic, lat, to, got.lat);
      end
      if (vm !== got.valm) begin
        errors++;
        $display("FAIL b2b_valm op%0d ic=%h: got %h want %h", i, o.ic, vm, got.valm);
      end
      if ({er, bz} !== {got.err, 1'b0}) begin
        errors++;
        $display("FAIL b2b_err_busy op%0d ic=%h: got %b want %b", i, o.ic, {er, bz}, {got.err, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_call_ret;
    test_fault_boundary;
    test_noop;
    test_busy_ignore;
    test_reset_mid_write;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
